// File: rtl/wave_buffer_ctrl_pkg.sv
// Shared types and default sizes for the ping-pong sample buffer controller.
package wave_buffer_ctrl_pkg;

  localparam int unsigned MAX_WR_WAIT_DEF = 4;
  localparam int unsigned ADDR_W_DEF      = 8;
  localparam int unsigned DATA_W_DEF      = 8;

  typedef enum logic [2:0] {
    ST_CAPTURE = 3'b001,
    ST_HOLD    = 3'b010,
    ST_SWAP    = 3'b100
  } bank_state_t;

endpackage

// File: rtl/wave_buffer_ctrl_if.sv
// Capture/display handshake bundle; master = capture/display clients, slave = buffer controller.
interface wave_buffer_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              cap_wr_req;
  logic [ADDR_W-1:0] cap_wr_addr;
  logic [DATA_W-1:0] cap_wr_data;
  logic              cap_wr_ack;
  logic              cap_frame_done;
  logic              cap_ready;
  logic              disp_rd_req;
  logic [ADDR_W-1:0] disp_rd_addr;
  logic              disp_rd_ack;
  logic              disp_rd_valid;
  logic [DATA_W-1:0] disp_rd_data;
  logic              disp_idle;
  logic              read_index;
  logic              swap_pulse;

  modport master (
    output cap_wr_req, cap_wr_addr, cap_wr_data, cap_frame_done,
           disp_rd_req, disp_rd_addr, disp_idle,
    input  cap_wr_ack, cap_ready, disp_rd_ack, disp_rd_valid, disp_rd_data,
           read_index, swap_pulse
  );

  modport slave (
    input  cap_wr_req, cap_wr_addr, cap_wr_data, cap_frame_done,
           disp_rd_req, disp_rd_addr, disp_idle,
    output cap_wr_ack, cap_ready, disp_rd_ack, disp_rd_valid, disp_rd_data,
           read_index, swap_pulse
  );
endinterface

// File: rtl/wave_buffer_ctrl_arb.sv
// Single-port RAM arbiter: reads win conflicts until a write has waited MAX_WR_WAIT cycles.
module wave_buffer_arb #(
  parameter int unsigned MAX_WR_WAIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic wr_req,
  input  logic wr_ready,
  input  logic rd_req,
  input  logic rd_allow,
  output logic wr_gnt,
  output logic rd_gnt
);

  localparam int unsigned WAIT_W = $clog2(MAX_WR_WAIT + 1);

  logic [WAIT_W-1:0] wr_wait;
  logic              wr_elig;
  logic              rd_elig;
  logic              starved;

  // Grants are suppressed while in reset so nothing reaches the RAM.
  always_comb begin
    wr_elig = wr_req & wr_ready & reset_n;
    rd_elig = rd_req & rd_allow & reset_n;
    starved = (wr_wait == WAIT_W'(MAX_WR_WAIT));
    wr_gnt  = wr_elig & (~rd_elig | starved);
    rd_gnt  = rd_elig & ~wr_gnt;
  end

  // A request blocked by cap_ready=0 neither counts nor clears.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_wait <= '0;
    end else if (!wr_req || wr_gnt) begin
      wr_wait <= '0;
    end else if (wr_ready && !starved) begin
      wr_wait <= wr_wait + WAIT_W'(1);
    end
  end

endmodule

// File: rtl/wave_buffer_ctrl.sv
// Ping-pong sample buffer controller: bank FSM, RAM mux and read-valid pipeline.
module wave_buffer_ctrl
  import wave_buffer_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WR_WAIT = MAX_WR_WAIT_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  wave_buffer_ctrl_if.slave bus,
  output logic [ADDR_W:0]   ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  bank_state_t state_q;
  bank_state_t state_d;
  logic        read_index_q;
  logic        rd_valid_q;
  logic        rd_allow;
  logic        wr_gnt;
  logic        rd_gnt;

  wave_buffer_arb #(
    .MAX_WR_WAIT (MAX_WR_WAIT)
  ) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_req   (bus.cap_wr_req),
    .wr_ready (bus.cap_ready),
    .rd_req   (bus.disp_rd_req),
    .rd_allow (rd_allow),
    .wr_gnt   (wr_gnt),
    .rd_gnt   (rd_gnt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_CAPTURE;
    end else begin
      state_q <= state_d;
    end
  end

  // Swap waits for an idle display with no read in flight.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CAPTURE: if (bus.cap_frame_done) state_d = ST_HOLD;
      ST_HOLD:    if (bus.disp_idle && !bus.disp_rd_req && !rd_valid_q) state_d = ST_SWAP;
      ST_SWAP:    state_d = ST_CAPTURE;
      default:    state_d = ST_CAPTURE;
    endcase
  end

  always_comb begin
    bus.cap_ready  = 1'b0;
    bus.swap_pulse = 1'b0;
    rd_allow       = 1'b1;
    unique case (state_q)
      ST_CAPTURE: bus.cap_ready = 1'b1;
      ST_HOLD:    ;
      ST_SWAP: begin
        bus.swap_pulse = 1'b1;
        rd_allow       = 1'b0;
      end
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      read_index_q <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      if (state_q == ST_SWAP) read_index_q <= ~read_index_q;
      rd_valid_q <= rd_gnt;
    end
  end

  // Capture always targets the bank the display does not own.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (wr_gnt) begin
      ram_addr  = {~read_index_q, bus.cap_wr_addr};
      ram_we    = 1'b1;
      ram_wdata = bus.cap_wr_data;
    end else if (rd_gnt) begin
      ram_addr  = {read_index_q, bus.disp_rd_addr};
    end
  end

  assign bus.cap_wr_ack    = wr_gnt;
  assign bus.disp_rd_ack   = rd_gnt;
  assign bus.disp_rd_valid = rd_valid_q;
  assign bus.disp_rd_data  = ram_rdata;
  assign bus.read_index    = read_index_q;

endmodule

// File: tb/tb_wave_buffer_ctrl.sv
// Self-checking bench for wave_buffer_ctrl with a behavioural RAM and a read-data scoreboard.
module tb_wave_buffer_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [8:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  wave_buffer_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  wave_buffer_ctrl #(.MAX_WR_WAIT(4), .ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_mem [512];
  logic [7:0] sb [$];
  logic       tb_ri = 1'b0;
  logic [7:0] mem [512];

  function automatic logic [7:0] init_val(int i);
    if (i == 16) return 8'h7E;
    return 8'(i) ^ 8'h5A;
  endfunction

  // Behavioural 512x8 RAM, read-before-write, 1-cycle read latency.
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      ram_rdata <= mem[ram_addr];
      if (ram_we === 1'b1) mem[ram_addr] = ram_wdata;
    end
  end

  task automatic monitor();
    logic [7:0] exp;
    if (bus.disp_rd_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_valid got data=%02h required no valid", bus.disp_rd_data);
      end else begin
        exp = sb.pop_front();
        if (bus.disp_rd_data !== exp) begin
          errors++;
          $display("FAIL sb_rd_data got=%02h required=%02h", bus.disp_rd_data, exp);
        end
      end
    end
    if (bus.disp_rd_ack === 1'b1) sb.push_back(exp_mem[{tb_ri, bus.disp_rd_addr}]);
    if (bus.cap_wr_ack === 1'b1) exp_mem[{~tb_ri, bus.cap_wr_addr}] = bus.cap_wr_data;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.cap_wr_req = 1'b1; bus.cap_wr_addr = 8'h01; bus.cap_wr_data = 8'hFF;
    bus.disp_rd_req = 1'b1; bus.disp_rd_addr = 8'h02;
    bus.cap_frame_done = 1'b0; bus.disp_idle = 1'b0;
    step(); step();
    checks++;
    if (bus.read_index !== 1'b0 || bus.cap_ready !== 1'b1 || ram_we !== 1'b0 ||
        bus.cap_wr_ack !== 1'b0 || bus.disp_rd_ack !== 1'b0 ||
        bus.swap_pulse !== 1'b0 || bus.disp_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset got ri=%b rdy=%b we=%b wack=%b rack=%b sw=%b v=%b required 0 1 0 0 0 0 0",
               bus.read_index, bus.cap_ready, ram_we, bus.cap_wr_ack, bus.disp_rd_ack,
               bus.swap_pulse, bus.disp_rd_valid);
    end
    bus.cap_wr_req = 1'b0; bus.disp_rd_req = 1'b0;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_lone_write();
    bus.cap_wr_req = 1'b1; bus.cap_wr_addr = 8'h05; bus.cap_wr_data = 8'hA3;
    #1;
    checks++;
    if (bus.cap_wr_ack !== 1'b1 || ram_addr !== 9'h105 || ram_we !== 1'b1 || ram_wdata !== 8'hA3) begin
      errors++;
      $display("FAIL lone_write got ack=%b addr=%03h we=%b wd=%02h required 1 105 1 a3",
               bus.cap_wr_ack, ram_addr, ram_we, ram_wdata);
    end
    step();
    bus.cap_wr_req = 1'b0;
  endtask

  task automatic test_lone_read();
    bus.disp_rd_req = 1'b1; bus.disp_rd_addr = 8'h10;
    #1;
    checks++;
    if (bus.disp_rd_ack !== 1'b1 || ram_addr !== 9'h010 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL lone_read_ack got ack=%b addr=%03h we=%b required 1 010 0",
               bus.disp_rd_ack, ram_addr, ram_we);
    end
    step();
    bus.disp_rd_req = 1'b0;
    #1;
    checks++;
    if (bus.disp_rd_valid !== 1'b1 || bus.disp_rd_data !== 8'h7E) begin
      errors++;
      $display("FAIL lone_read_data got v=%b d=%02h required 1 7e", bus.disp_rd_valid, bus.disp_rd_data);
    end
    step();
  endtask

  task automatic test_starvation();
    bus.disp_rd_req = 1'b1; bus.disp_rd_addr = 8'h20;
    bus.cap_wr_req = 1'b1; bus.cap_wr_addr = 8'h30; bus.cap_wr_data = 8'hC5;
    for (int c = 1; c <= 6; c++) begin
      #1;
      checks++;
      if (bus.cap_wr_ack !== (c == 5) || bus.disp_rd_ack !== (c != 5)) begin
        errors++;
        $display("FAIL starve_cycle%0d got wack=%b rack=%b required %b %b",
                 c, bus.cap_wr_ack, bus.disp_rd_ack, c == 5, c != 5);
      end
      step();
      if (c == 5) bus.cap_wr_req = 1'b0;
    end
    bus.disp_rd_req = 1'b0;
    step(); step();
  endtask

  task automatic test_frame_swap();
    bus.cap_frame_done = 1'b1; bus.disp_idle = 1'b0;
    bus.cap_wr_req = 1'b1; bus.cap_wr_addr = 8'h07; bus.cap_wr_data = 8'h11;
    #1;
    checks++;
    if (bus.cap_wr_ack !== 1'b1 || ram_addr !== 9'h107) begin
      errors++;
      $display("FAIL done_write got ack=%b addr=%03h required 1 107", bus.cap_wr_ack, ram_addr);
    end
    step();
    bus.cap_frame_done = 1'b0; bus.cap_wr_addr = 8'h08;
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++;
      if (bus.cap_ready !== 1'b0 || bus.cap_wr_ack !== 1'b0 || ram_we !== 1'b0 ||
          bus.read_index !== 1'b0 || bus.swap_pulse !== 1'b0) begin
        errors++;
        $display("FAIL hold_busy%0d got rdy=%b wack=%b we=%b ri=%b sw=%b required 0 0 0 0 0",
                 c, bus.cap_ready, bus.cap_wr_ack, ram_we, bus.read_index, bus.swap_pulse);
      end
      step();
    end
    bus.cap_wr_req = 1'b0;
    bus.disp_idle = 1'b1;
    step();
    bus.disp_rd_req = 1'b1; bus.disp_rd_addr = 8'h07;
    #1;
    checks++;
    if (bus.swap_pulse !== 1'b1 || bus.read_index !== 1'b0 || bus.cap_ready !== 1'b0 ||
        bus.disp_rd_ack !== 1'b0) begin
      errors++;
      $display("FAIL swap_cycle got sw=%b ri=%b rdy=%b rack=%b required 1 0 0 0",
               bus.swap_pulse, bus.read_index, bus.cap_ready, bus.disp_rd_ack);
    end
    step();
    tb_ri = 1'b1;
    #1;
    checks++;
    if (bus.swap_pulse !== 1'b0 || bus.read_index !== 1'b1 || bus.cap_ready !== 1'b1 ||
        bus.disp_rd_ack !== 1'b1 || ram_addr !== 9'h107) begin
      errors++;
      $display("FAIL after_swap got sw=%b ri=%b rdy=%b rack=%b addr=%03h required 0 1 1 1 107",
               bus.swap_pulse, bus.read_index, bus.cap_ready, bus.disp_rd_ack, ram_addr);
    end
    step();
    bus.disp_rd_addr = 8'h30;
    step();
    bus.disp_rd_req = 1'b0;
    step();
  endtask

  task automatic test_write_after_swap();
    bus.cap_wr_req = 1'b1; bus.cap_wr_addr = 8'h00; bus.cap_wr_data = 8'h3C;
    #1;
    checks++;
    if (bus.cap_wr_ack !== 1'b1 || ram_addr !== 9'h000 || ram_we !== 1'b1) begin
      errors++;
      $display("FAIL write_after_swap got ack=%b addr=%03h we=%b required 1 000 1",
               bus.cap_wr_ack, ram_addr, ram_we);
    end
    step();
    bus.cap_wr_req = 1'b0;
    bus.disp_idle = 1'b0;
    step();
  endtask

  task automatic test_reset_in_hold();
    bus.cap_frame_done = 1'b1;
    step();
    bus.cap_frame_done = 1'b0;
    #1;
    checks++;
    if (bus.cap_ready !== 1'b0) begin
      errors++;
      $display("FAIL enter_hold got rdy=%b required 0", bus.cap_ready);
    end
    reset_n = 1'b0;
    bus.cap_wr_req = 1'b1; bus.cap_wr_addr = 8'h44;
    #1;
    checks++;
    if (ram_we !== 1'b0 || bus.cap_wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_cycle_write got we=%b ack=%b required 0 0", ram_we, bus.cap_wr_ack);
    end
    step();
    reset_n = 1'b1;
    bus.cap_wr_req = 1'b0;
    tb_ri = 1'b0;
    #1;
    checks++;
    if (bus.cap_ready !== 1'b1 || bus.read_index !== 1'b0) begin
      errors++;
      $display("FAIL reset_from_hold got rdy=%b ri=%b required 1 0", bus.cap_ready, bus.read_index);
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) exp_mem[i] = init_val(i);
    test_reset();
    test_lone_write();
    test_lone_read();
    test_starvation();
    test_frame_swap();
    test_write_after_swap();
    test_reset_in_hold();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got pending=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
